// File: rtl/aes_dec_controller.sv
// Control FSM for an iterative AES-128 decryption datapath: key expansion,
// then inverse rounds from key 10 down to key 0, with key reuse and abort.
module aes_dec_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       input_valid,
    input  logic       key_reuse,
    input  logic       abort,
    output logic       input_ready,
    output logic       load_state,
    output logic       enable_key_expansion,
    output logic       enable_add_round_key,
    output logic       enable_inv_shift_rows,
    output logic       enable_inv_sub_bytes,
    output logic       enable_inv_mix_columns,
    output logic [3:0] round_counter,
    output logic [2:0] current_state,
    output logic       key_valid,
    output logic       output_valid
);

    typedef enum logic [2:0] {
        IDLE            = 3'b000,
        INITIAL_ROUND   = 3'b001,
        KEY_EXPANSION   = 3'b010,
        INV_SUB_BYTES   = 3'b011,
        INV_SHIFT_ROWS  = 3'b100,
        INV_MIX_COLUMNS = 3'b101,
        ADD_ROUND_KEY   = 3'b110,
        DONE            = 3'b111
    } state_t;

    state_t     state, next_state;
    logic [3:0] rc, next_rc;
    logic       kv, next_kv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rc    <= 4'd0;
            kv    <= 1'b0;
        end else begin
            state <= next_state;
            rc    <= next_rc;
            kv    <= next_kv;
        end
    end

    always_comb begin
        next_state             = state;
        next_rc                = rc;
        next_kv                = kv;
        input_ready            = 1'b0;
        load_state             = 1'b0;
        enable_key_expansion   = 1'b0;
        enable_add_round_key   = 1'b0;
        enable_inv_shift_rows  = 1'b0;
        enable_inv_sub_bytes   = 1'b0;
        enable_inv_mix_columns = 1'b0;
        output_valid           = 1'b0;

        case (state)
            IDLE: begin
                input_ready = 1'b1;
                if (input_valid && !abort) begin
                    load_state = 1'b1;
                    if (key_reuse && kv) begin
                        next_state = INITIAL_ROUND;
                        next_rc    = 4'd10;
                    end else begin
                        next_state = KEY_EXPANSION;
                        next_rc    = 4'd1;
                        next_kv    = 1'b0;
                    end
                end
            end
            KEY_EXPANSION: begin
                enable_key_expansion = 1'b1;
                if (rc == 4'd10) begin
                    next_state = INITIAL_ROUND;
                    next_kv    = 1'b1;
                end else begin
                    next_rc = rc + 4'd1;
                end
            end
            INITIAL_ROUND: begin
                enable_add_round_key = 1'b1;
                next_state           = INV_SHIFT_ROWS;
                next_rc              = 4'd9;
            end
            INV_SHIFT_ROWS: begin
                enable_inv_shift_rows = 1'b1;
                next_state            = INV_SUB_BYTES;
            end
            INV_SUB_BYTES: begin
                enable_inv_sub_bytes = 1'b1;
                next_state           = ADD_ROUND_KEY;
            end
            ADD_ROUND_KEY: begin
                enable_add_round_key = 1'b1;
                // Final round has no InvMixColumns, so key 0 ends the block.
                if (rc == 4'd0) begin
                    next_state = DONE;
                end else begin
                    next_state = INV_MIX_COLUMNS;
                    next_rc    = rc - 4'd1;
                end
            end
            INV_MIX_COLUMNS: begin
                enable_inv_mix_columns = 1'b1;
                next_state             = INV_SHIFT_ROWS;
            end
            DONE: begin
                output_valid = 1'b1;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // Abort keeps the stored-key flag as it was; partial key sets stay invalid.
        if (abort && state != IDLE) begin
            next_state = IDLE;
            next_rc    = rc;
            next_kv    = kv;
        end
    end

    assign round_counter = rc;
    assign current_state = state;
    assign key_valid     = kv;

endmodule
